// File: rtl/ac_ostream.sv
// ac_ostream: drains a wide line buffer into an AXI-Stream master tagged with SOF (tuser) and EOL (tlast).
// Define AC_OSTREAM_STALL_CNT_EN to build the stall cycle counter; otherwise stall_cnt is tied to 0.
module ac_ostream #(
    parameter int UPSP_WRTDATA_WIDTH = 24,
    parameter int N_PARALLEL         = 2,
    parameter int DST_IMG_WIDTH      = 4096,
    parameter int DST_IMG_HEIGHT     = 2160
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    output logic                                     buf_rd,
    input  logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0] buf_rdata,
    input  logic                                     buf_empty,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0] m_axis_tdata,
    output logic                                     m_axis_tlast,
    output logic                                     m_axis_tuser,
    output logic                                     frame_done,
    output logic [31:0]                              stall_cnt
);
    localparam int N_UPSP_WRT    = UPSP_WRTDATA_WIDTH / 24;
    localparam int BEATS_PER_ROW = ((DST_IMG_WIDTH / N_UPSP_WRT) + N_PARALLEL - 1) / N_PARALLEL;
    localparam int DW            = UPSP_WRTDATA_WIDTH * N_PARALLEL;
    localparam int BW            = BEATS_PER_ROW > 1 ? $clog2(BEATS_PER_ROW) : 1;
    localparam int RW            = DST_IMG_HEIGHT > 1 ? $clog2(DST_IMG_HEIGHT) : 1;

    typedef struct packed {
        logic          eof;
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    typedef enum logic [1:0] {IDLE, RUN, EOF} state_t;

    ent_t          q0, q1, nq0, nq1, ent;
    logic [1:0]    vld, nvld, occ;
    logic          in_flight, pop, beat_end, row_end;
    logic [BW-1:0] beat;
    logic [RW-1:0] row;
    state_t        state;

    assign pop      = vld[0] & m_axis_tready;
    // slots that will be committed once this cycle's pop is taken into account
    assign occ      = 2'(vld[0]) + 2'(vld[1]) + 2'(in_flight) - 2'(pop);
    assign buf_rd   = rst_n & ~buf_empty & (occ < 2'd2);
    assign beat_end = beat == BW'(BEATS_PER_ROW - 1);
    assign row_end  = row == RW'(DST_IMG_HEIGHT - 1);
    assign ent      = '{eof: beat_end & row_end, user: (beat == '0) && (row == '0),
                        last: beat_end, data: buf_rdata};

    assign m_axis_tvalid = vld[0];
    assign m_axis_tdata  = q0.data;
    assign m_axis_tlast  = q0.last;
    assign m_axis_tuser  = q0.user;

    // next queue contents: shift on pop, then append the returning read behind whatever remains
    always_comb begin
        nq0  = pop ? q1 : q0;
        nq1  = q1;
        nvld = pop ? {1'b0, vld[1]} : vld;
        if (in_flight) begin
            if (nvld[0]) begin
                nq1     = ent;
                nvld[1] = 1'b1;
            end else begin
                nq0     = ent;
                nvld[0] = 1'b1;
            end
        end
    end

    // queue, read-in-flight flag and beat/row position of the next entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0        <= '0;
            q1        <= '0;
            vld       <= '0;
            in_flight <= 1'b0;
            beat      <= '0;
            row       <= '0;
        end else begin
            q0        <= nq0;
            q1        <= nq1;
            vld       <= nvld;
            in_flight <= buf_rd;
            if (in_flight) begin
                beat <= beat_end ? '0 : beat + 1'b1;
                if (beat_end)
                    row <= row_end ? '0 : row + 1'b1;
            end
        end
    end

    // frame sequencing; frame_done pulses the cycle after the frame's final beat handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop & q0.eof;
            case (state)
                IDLE:    state <= buf_rd ? RUN : IDLE;
                RUN:     state <= (pop & q0.eof) ? EOF : RUN;
                EOF:     state <= (pop & q0.eof) ? EOF : ((|nvld || buf_rd) ? RUN : IDLE);
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AC_OSTREAM_STALL_CNT_EN
    // saturating count of cycles where a beat is offered but not accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (vld[0] & ~m_axis_tready & ~&stall_cnt)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ac_ostream.sv
// tb_ac_ostream: randomized bench for ac_ostream with a queue-based scoreboard of the expected stream.
module tb_ac_ostream;
    localparam int UW  = 24;
    localparam int NP  = 2;
    localparam int W   = 16;
    localparam int H   = 2;
    localparam int DW  = UW * NP;
    localparam int BPR = (W / (UW / 24) + NP - 1) / NP;
    localparam int FB  = BPR * H;
`ifdef AC_OSTREAM_STALL_CNT_EN
    localparam logic [31:0] STALL5 = 32'd5;
`else
    localparam logic [31:0] STALL5 = 32'd0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, buf_empty = 1'b1, tready = 1'b0;
    logic          buf_rd, tvalid, tlast, tuser, frame_done;
    logic [DW-1:0] buf_rdata = '0, tdata;
    logic [31:0]   stall_cnt;

    ac_ostream #(.UPSP_WRTDATA_WIDTH(UW), .N_PARALLEL(NP), .DST_IMG_WIDTH(W), .DST_IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .buf_rd(buf_rd), .buf_rdata(buf_rdata), .buf_empty(buf_empty),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser), .frame_done(frame_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int            checks = 0, errors = 0, cyc = 0, k = 0;
    logic [DW-1:0] exp_q[$];
    int            hs_at[$];
    logic          hs_user[$];
    logic          fd_pend = 1'b0, hold_v = 1'b0, rd_s = 1'b0;
    logic [DW+1:0] hold_d;
    logic [31:0]   stall_exp = '0;
    logic [DW-1:0] nw, pend, ex;

    function automatic logic [DW-1:0] rnd();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DW-1:0];
    endfunction

    initial nw = rnd();

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_s) buf_rdata <= pend;
    end

    // reference model: every read returns the next word, beats leave in read order,
    // beat k since reset is EOL when k mod BPR = BPR-1 and SOF when k mod FB = 0
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            k = 0; fd_pend = 0; hold_v = 0; stall_exp = '0; rd_s = 0;
        end else begin
            checks++;
            if (frame_done !== fd_pend) begin
                errors++; $display("FAIL frame_done cyc %0d: got %b want %b", cyc, frame_done, fd_pend);
            end
            checks++;
            if (stall_cnt !== stall_exp) begin
                errors++; $display("FAIL stall_cnt cyc %0d: got %0d want %0d", cyc, stall_cnt, stall_exp);
            end
            checks++;
            if (exp_q.size() > 2) begin
                errors++; $display("FAIL outstanding cyc %0d: got %0d want <=2", cyc, exp_q.size());
            end
            if (hold_v) begin
                checks++;
                if (tvalid !== 1'b1 || {tlast, tuser, tdata} !== hold_d) begin
                    errors++; $display("FAIL hold cyc %0d: got v=%b %h want v=1 %h", cyc, tvalid, {tlast, tuser, tdata}, hold_d);
                end
            end
            fd_pend = 0;
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL extra_beat cyc %0d: got beat %h want none", cyc, tdata);
                end else begin
                    ex = exp_q.pop_front();
                    if ({tlast, tuser, tdata} !== {(k % BPR) == BPR - 1, (k % FB) == 0, ex}) begin
                        errors++;
                        $display("FAIL beat%0d cyc %0d: got l=%b u=%b %h want l=%b u=%b %h", k, cyc, tlast, tuser, tdata,
                                 (k % BPR) == BPR - 1, (k % FB) == 0, ex);
                    end
                end
                fd_pend = (k % FB) == FB - 1;
                hs_at.push_back(cyc);
                hs_user.push_back(tuser);
                k++;
            end
            hold_v = tvalid && !tready;
            hold_d = {tlast, tuser, tdata};
`ifdef AC_OSTREAM_STALL_CNT_EN
            if (tvalid && !tready) stall_exp++;
`endif
            rd_s = buf_rd;
            if (buf_rd) begin
                exp_q.push_back(nw);
                pend = nw;
                nw = rnd();
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_hs(input int n, output bit ok);
        int i = 0;
        while (hs_at.size() < n && i < 300) begin
            @(negedge clk); #2; i++;
        end
        ok = hs_at.size() >= n;
    endtask

    task automatic test_reset();
        rst_n = 0; buf_empty = 0; tready = 1;
        repeat (3) tick();
        checks++;
        if ({buf_rd, tvalid, tlast, tuser, frame_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {buf_rd, tvalid, tlast, tuser, frame_done});
        end
        checks++;
        if (tdata !== '0 || stall_cnt !== '0) begin
            errors++; $display("FAIL reset_data: got %h/%0d want 0/0", tdata, stall_cnt);
        end
    endtask

    task automatic test_stream();
        bit ok;
        int start, bad = 0;
        hs_at.delete(); hs_user.delete();
        rst_n = 1;
        start = cyc;
        wait_hs(16, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL stream_timeout: got %0d beats want 16", hs_at.size());
        end else begin
            for (int i = 1; i < 16; i++) if (hs_at[i] - hs_at[i-1] != 1) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL stream_gaps: got %0d gaps want 0", bad);
            end
            checks++;
            if (hs_at[0] - start != 2) begin
                errors++; $display("FAIL stream_latency: got %0d want 2", hs_at[0] - start);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_hs(32, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_timeout: got %0d beats want 32", hs_at.size());
        end else begin
            checks++;
            if (hs_at[16] - hs_at[15] != 1 || hs_user[16] !== 1'b1) begin
                errors++; $display("FAIL b2b_sof: got gap %0d u=%b want gap 1 u=1", hs_at[16] - hs_at[15], hs_user[16]);
            end
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        tick();
        tready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            if (buf_rd !== 1'b0 || tvalid !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_rd: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (exp_q.size() != 2) begin
            errors++; $display("FAIL stall_full: got %0d outstanding want 2", exp_q.size());
        end
        tready = 1;
        @(negedge clk); #2;
        checks++;
        if (stall_cnt !== STALL5) begin
            errors++; $display("FAIL stall_cnt5: got %0d want %0d", stall_cnt, STALL5);
        end
    endtask

    task automatic test_toggle();
        int n0;
        n0 = hs_at.size();
        for (int i = 0; i < 60; i++) begin
            buf_empty = i[0];
            tick();
        end
        checks++;
        if (hs_at.size() - n0 < 25 || hs_at.size() - n0 > 32) begin
            errors++; $display("FAIL toggle_rate: got %0d beats want 25..32", hs_at.size() - n0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            buf_empty = $urandom_range(0, 3) == 0;
            tready = $urandom_range(0, 2) != 0;
            tick();
        end
        buf_empty = 1; tready = 1;
        repeat (6) tick();
        checks++;
        if (exp_q.size() != 0 || tvalid !== 1'b0) begin
            errors++; $display("FAIL drain: got %0d left v=%b want 0 v=0", exp_q.size(), tvalid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int i = 0;
        rst_n = 0; tick(); tick();
        buf_empty = 0; tready = 1; rst_n = 1;
        while (k < 10 && i < 100) begin
            @(negedge clk); #2; i++;
        end
        checks++;
        if (k != 10) begin
            errors++; $display("FAIL mid_reach: got beat %0d want 10", k);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({buf_rd, tvalid, tlast, tuser, frame_done} !== 5'b0 || tdata !== '0 || stall_cnt !== '0) begin
            errors++; $display("FAIL mid_reset_out: got %b %h %0d want 0", {buf_rd, tvalid, tlast, tuser, frame_done}, tdata, stall_cnt);
        end
        tick(); tick();
        hs_at.delete(); hs_user.delete();
        rst_n = 1;
        wait_hs(1, ok);
        checks++;
        if (!ok || hs_user[0] !== 1'b1) begin
            errors++; $display("FAIL mid_sof: got ok=%b u=%b want 1/1", ok, ok ? hs_user[0] : 1'bx);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_stall();
        test_toggle();
        test_random();
        test_reset_mid();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
